// File: rtl/op4_operand_collector.sv
// rtl/op4_operand_collector.sv - packs FP32 words into {a,b,c,d} sets in a ping-pong buffer
// and hands each set to the 4-input sum stage over an STB/BUSY handshake.
module op4_operand_collector #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     word_in,
  input  logic                 word_last,
  input  logic                 word_input_STB,
  output logic                 collector_BUSY,
  input  logic                 flush,
  output logic [WIDTH-1:0]     input_a,
  output logic [WIDTH-1:0]     input_b,
  output logic [WIDTH-1:0]     input_c,
  output logic [WIDTH-1:0]     input_d,
  output logic                 op4_input_STB,
  input  logic                 op4_BUSY,
  output logic                 frame_err,
  output logic [CNT_WIDTH-1:0] set_count
);

  typedef enum logic [1:0] {IDLE, LAUNCH, HOLD} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     bank_q [2][4];
  logic [1:0]           full_q, full_d;
  logic [1:0]           idx_q;
  logic                 wr_bank_q;
  logic                 rd_bank_q;
  logic                 frame_err_q;
  logic [CNT_WIDTH-1:0] set_count_q;

  logic accept;
  logic complete;
  logic release_set;
  logic launch_ok;

  assign collector_BUSY = full_q[wr_bank_q];
  assign accept         = word_input_STB && !collector_BUSY && !flush;
  assign complete       = accept && (idx_q == 2'd3);
  assign release_set    = (state_q == HOLD) && !op4_BUSY;
  // A set completing into rd_bank this cycle launches immediately, saving one cycle of latency.
  assign launch_ok      = full_q[rd_bank_q] || (complete && (wr_bank_q == rd_bank_q));

  always_comb begin
    full_d = full_q;
    if (release_set) full_d[rd_bank_q] = 1'b0;
    if (complete)    full_d[wr_bank_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch_ok)   state_d = LAUNCH;
      LAUNCH:  if (op4_BUSY)    state_d = HOLD;
      HOLD:    if (release_set) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_comb begin
    op4_input_STB = (state_q == LAUNCH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int s = 0; s < 4; s++) bank_q[b][s] <= '0;
      end
      full_q      <= 2'b00;
      idx_q       <= 2'd0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      frame_err_q <= 1'b0;
      set_count_q <= '0;
    end else begin
      full_q <= full_d;
      if (accept) bank_q[wr_bank_q][idx_q] <= word_in;
      if (flush) begin
        idx_q <= 2'd0;
      end else if (accept) begin
        if (idx_q == 2'd3) begin
          idx_q     <= 2'd0;
          wr_bank_q <= ~wr_bank_q;
        end else if (word_last) begin
          idx_q       <= 2'd0;
          frame_err_q <= 1'b1;
        end else begin
          idx_q <= idx_q + 2'd1;
        end
      end
      if (release_set) begin
        rd_bank_q   <= ~rd_bank_q;
        set_count_q <= set_count_q + CNT_WIDTH'(1);
      end
    end
  end

  assign input_a   = bank_q[rd_bank_q][0];
  assign input_b   = bank_q[rd_bank_q][1];
  assign input_c   = bank_q[rd_bank_q][2];
  assign input_d   = bank_q[rd_bank_q][3];
  assign frame_err = frame_err_q;
  assign set_count = set_count_q;

endmodule

// File: tb/tb_op4_operand_collector.sv
// tb/tb_op4_operand_collector.sv - scenario bench for op4_operand_collector with a
// queue-based set model and a behavioural sum-stage responder.
module tb_op4_operand_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] word_in;
  logic        word_last;
  logic        word_input_STB;
  logic        collector_BUSY;
  logic        flush;
  logic [31:0] input_a, input_b, input_c, input_d;
  logic        op4_input_STB;
  logic        op4_BUSY;
  logic        frame_err;
  logic [15:0] set_count;

  op4_operand_collector #(.WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .word_in(word_in), .word_last(word_last),
    .word_input_STB(word_input_STB), .collector_BUSY(collector_BUSY), .flush(flush),
    .input_a(input_a), .input_b(input_b), .input_c(input_c), .input_d(input_d),
    .op4_input_STB(op4_input_STB), .op4_BUSY(op4_BUSY), .frame_err(frame_err),
    .set_count(set_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0]  part[$];
  logic [127:0] exp_q[$];
  logic         exp_fe = 1'b0;
  int           released = 0;
  int           hold_cycles = 2;

  task automatic model_reset();
    part.delete();
    exp_q.delete();
    exp_fe   = 1'b0;
    released = 0;
  endtask

  task automatic model_accept(input logic [31:0] w, input logic last);
    part.push_back(w);
    if (part.size() == 4) begin
      exp_q.push_back({part[0], part[1], part[2], part[3]});
      part.delete();
    end else if (last) begin
      part.delete();
      exp_fe = 1'b1;
    end
  endtask

  // Sum-stage model: grab the set on STB, hold BUSY, require stable operands throughout.
  initial begin
    logic [127:0] cur;
    op4_BUSY = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && op4_input_STB) begin
        cur = {input_a, input_b, input_c, input_d};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_set: got %h required none", cur);
        end else begin
          if (cur !== exp_q[0]) begin
            n_err++;
            $display("FAIL set_order: got %h required %h", cur, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        op4_BUSY = 1'b1;
        for (int i = 0; i < hold_cycles; i++) begin
          @(negedge clk);
          if (rst) break;
          n_cmp++;
          if ({input_a, input_b, input_c, input_d} !== cur) begin
            n_err++;
            $display("FAIL hold_stable: got %h required %h", {input_a, input_b, input_c, input_d}, cur);
          end
        end
        op4_BUSY = 1'b0;
        if (!rst) released++;
      end
    end
  end

  task automatic send_word(input logic [31:0] w, input logic last, output int stalls);
    stalls = 0;
    @(negedge clk);
    word_in        = w;
    word_last      = last;
    word_input_STB = 1'b1;
    while (collector_BUSY && stalls < 500) begin
      @(negedge clk);
      stalls++;
    end
    if (stalls >= 500) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got busy for %0d cycles required release", stalls);
      word_input_STB = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    word_input_STB = 1'b0;
    word_last      = 1'b0;
    model_accept(w, last);
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush          = 1'b1;
    word_input_STB = 1'b1;
    word_in        = $urandom;
    @(posedge clk);
    #1;
    flush          = 1'b0;
    word_input_STB = 1'b0;
    part.delete();
  endtask

  task automatic drain(input string tag);
    int c;
    c = 0;
    while (c < 2000) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !op4_BUSY && !op4_input_STB) break;
      c++;
    end
    @(negedge clk);
    n_cmp++;
    if (c >= 2000) begin
      n_err++;
      $display("FAIL %s_drain: got %0d sets pending required 0", tag, exp_q.size());
    end
    n_cmp++;
    if (set_count !== 16'(released)) begin
      n_err++;
      $display("FAIL %s_set_count: got %0d required %0d", tag, set_count, released);
    end
    n_cmp++;
    if (frame_err !== exp_fe) begin
      n_err++;
      $display("FAIL %s_frame_err: got %b required %b", tag, frame_err, exp_fe);
    end
    n_cmp++;
    if (collector_BUSY !== 1'b0) begin
      n_err++;
      $display("FAIL %s_busy_idle: got %b required 0", tag, collector_BUSY);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_cmp++;
    if ({collector_BUSY, op4_input_STB, frame_err} !== 3'b000 || set_count !== 16'd0) begin
      n_err++;
      $display("FAIL %s_ctrl: got busy=%b stb=%b fe=%b cnt=%0d required 0", tag,
               collector_BUSY, op4_input_STB, frame_err, set_count);
    end
    n_cmp++;
    if ({input_a, input_b, input_c, input_d} !== 128'd0) begin
      n_err++;
      $display("FAIL %s_operands: got %h required 0", tag, {input_a, input_b, input_c, input_d});
    end
  endtask

  task automatic wait_busy(input string tag);
    int c;
    c = 0;
    while (!op4_BUSY && c < 200) begin
      @(negedge clk);
      c++;
    end
    if (c >= 200) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_wait_busy: got op4_BUSY=0 required 1", tag);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; word_in = '0; word_last = 1'b0; word_input_STB = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    logic [31:0] w [4];
    int st;
    w[0] = 32'h3F800000; w[1] = 32'h40000000; w[2] = 32'h40400000; w[3] = 32'h40800000;
    hold_cycles = 2;
    for (int i = 0; i < 4; i++) send_word(w[i], i == 3, st);
    @(negedge clk);
    n_cmp++;
    if (op4_input_STB !== 1'b1) begin
      n_err++;
      $display("FAIL basic_latency: got stb=%b required 1", op4_input_STB);
    end
    drain("basic");
    n_cmp++;
    if (set_count !== 16'd1) begin
      n_err++;
      $display("FAIL basic_count_one: got %0d required 1", set_count);
    end
  endtask

  task automatic test_back_to_back();
    int st;
    hold_cycles = 20;
    for (int i = 0; i < 12; i++) begin
      send_word($urandom, (i % 4) == 3, st);
      n_cmp++;
      if ((i == 8) ? (st == 0) : (st != 0)) begin
        n_err++;
        $display("FAIL b2b_stall_word%0d: got %0d stall cycles required %s", i + 1, st,
                 (i == 8) ? ">0" : "0");
      end
    end
    drain("b2b");
  endtask

  task automatic test_hold_stable();
    int st;
    hold_cycles = 15;
    for (int i = 0; i < 4; i++) send_word($urandom, i == 3, st);
    wait_busy("hold");
    for (int i = 0; i < 4; i++) send_word($urandom, 1'b0, st);
    drain("hold");
  endtask

  task automatic test_frame_err();
    int st;
    hold_cycles = 3;
    send_word($urandom, 1'b0, st);
    send_word($urandom, 1'b1, st);
    @(negedge clk);
    n_cmp++;
    if (frame_err !== 1'b1) begin
      n_err++;
      $display("FAIL frame_err_set: got %b required 1", frame_err);
    end
    for (int i = 0; i < 4; i++) send_word($urandom, i == 3, st);
    drain("frame");
  endtask

  task automatic test_flush();
    int st;
    hold_cycles = 2;
    send_word($urandom, 1'b0, st);
    send_word($urandom, 1'b0, st);
    do_flush();
    for (int i = 0; i < 4; i++) send_word($urandom, i == 3, st);
    drain("flush");
  endtask

  task automatic test_reset_in_hold();
    int st;
    hold_cycles = 50;
    for (int i = 0; i < 4; i++) send_word($urandom, i == 3, st);
    wait_busy("rsthold");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rsthold");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    hold_cycles = 2;
    for (int i = 0; i < 4; i++) send_word($urandom, i == 3, st);
    @(negedge clk);
    n_cmp++;
    if (op4_input_STB !== 1'b1) begin
      n_err++;
      $display("FAIL rsthold_relaunch: got stb=%b required 1", op4_input_STB);
    end
    drain("rsthold");
  endtask

  task automatic test_random();
    int st;
    int r;
    for (int n = 0; n < 120; n++) begin
      hold_cycles = $urandom_range(1, 8);
      r = $urandom_range(0, 19);
      if (r == 0) do_flush();
      else        send_word($urandom, (r == 1) || (part.size() == 3), st);
    end
    drain("random");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_hold_stable();
    test_frame_err();
    test_flush();
    test_reset_in_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
